// File: rtl/fb_access_scheduler.sv
// Framebuffer access scheduler: arbitrates scanout reads and draw writes onto a
// single-outstanding memory bus and defers buffer flips to end-of-frame.
// Optional FB_FLIP_COUNT_EN adds a 16-bit flip_count output.
module fb_access_scheduler #(
  parameter int MAX_SCAN_RUN = 8,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        scan_req,
  input  logic [8:0]  scan_x,
  input  logic [7:0]  scan_y,
  output logic        scan_ack,
  output logic [31:0] scan_rdata,
  input  logic        scan_frame_end,
  input  logic        draw_req,
  input  logic [8:0]  draw_x,
  input  logic [7:0]  draw_y,
  input  logic [31:0] draw_wdata,
  output logic        draw_ack,
  input  logic        draw_frame_done,
  output logic        flip_pending,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_back,
  output logic [8:0]  mem_x,
  output logic [7:0]  mem_y,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        flip_buffer,
  output logic        mem_error
`ifdef FB_FLIP_COUNT_EN
  ,
  output logic [15:0] flip_count
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN_ACC, DRAW_ACC} state_t;

  state_t     state, state_next;
  logic [7:0] run_cnt;
  logic [7:0] wait_cnt;
  logic       frame_end_seen;
  logic       draw_elig, grant_scan, grant_draw, do_flip, done, abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // The ack cycle is already IDLE, but the requester still holds req there,
  // so granting is suppressed until the ack pulse has gone.
  always_comb begin
    state_next = state;
    draw_elig  = draw_req && !flip_pending;
    grant_scan = 1'b0;
    grant_draw = 1'b0;
    do_flip    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (flip_pending && frame_end_seen) begin
          do_flip = 1'b1;
        end else if (!(scan_ack || draw_ack)) begin
          if (draw_elig && (!scan_req || run_cnt >= 8'(MAX_SCAN_RUN))) begin
            grant_draw = 1'b1;
            state_next = DRAW_ACC;
          end else if (scan_req) begin
            grant_scan = 1'b1;
            state_next = SCAN_ACC;
          end
        end
      end
      SCAN_ACC, DRAW_ACC: begin
        if (mem_ack) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == 8'(ACK_TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_back   <= 1'b0;
      mem_x      <= '0;
      mem_y      <= '0;
      mem_wdata  <= '0;
      wait_cnt   <= '0;
      scan_ack   <= 1'b0;
      draw_ack   <= 1'b0;
      scan_rdata <= '0;
      mem_error  <= 1'b0;
    end else begin
      scan_ack <= done && (state == SCAN_ACC);
      draw_ack <= done && (state == DRAW_ACC);
      if (grant_scan || grant_draw) begin
        mem_req   <= 1'b1;
        mem_we    <= grant_draw;
        mem_back  <= grant_draw;
        mem_x     <= grant_draw ? draw_x : scan_x;
        mem_y     <= grant_draw ? draw_y : scan_y;
        mem_wdata <= grant_draw ? draw_wdata : 32'h0;
        wait_cnt  <= '0;
      end else if (done || abort) begin
        mem_req <= 1'b0;
      end else if (mem_req) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (done && (state == SCAN_ACC)) scan_rdata <= mem_rdata;
      if (abort) mem_error <= 1'b1;
    end
  end

  // Any IDLE cycle consumes frame_end_seen: either it fires the flip or it is stale.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run_cnt        <= '0;
      flip_pending   <= 1'b0;
      frame_end_seen <= 1'b0;
      flip_buffer    <= 1'b0;
    end else begin
      flip_buffer <= do_flip;
      if (grant_draw)
        run_cnt <= '0;
      else if (grant_scan && draw_elig && run_cnt != 8'hFF)
        run_cnt <= run_cnt + 8'd1;
      if (do_flip)              flip_pending <= 1'b0;
      else if (draw_frame_done) flip_pending <= 1'b1;
      if (scan_frame_end)       frame_end_seen <= 1'b1;
      else if (state == IDLE)   frame_end_seen <= 1'b0;
    end
  end

`ifdef FB_FLIP_COUNT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       flip_count <= '0;
    else if (do_flip) flip_count <= flip_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Directed bench for fb_access_scheduler: vector table of single transactions
// plus hand-written sequences for starvation, flips, timeout and reset.
module tb_fb_access_scheduler;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        scan_req = 1'b0, draw_req = 1'b0;
  logic [8:0]  scan_x = '0, draw_x = '0;
  logic [7:0]  scan_y = '0, draw_y = '0;
  logic [31:0] draw_wdata = '0;
  logic        scan_frame_end = 1'b0, draw_frame_done = 1'b0;
  logic        scan_ack, draw_ack, flip_pending, mem_req, mem_we, mem_back;
  logic        flip_buffer, mem_error;
  logic [31:0] scan_rdata, mem_wdata;
  logic [8:0]  mem_x;
  logic [7:0]  mem_y;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef FB_FLIP_COUNT_EN
  logic [15:0] flip_count;
`endif

  int checks = 0;
  int errors = 0;

  fb_access_scheduler #(.MAX_SCAN_RUN(8), .ACK_TIMEOUT(64)) dut (
    .clk(clk), .n_rst(n_rst),
    .scan_req(scan_req), .scan_x(scan_x), .scan_y(scan_y),
    .scan_ack(scan_ack), .scan_rdata(scan_rdata), .scan_frame_end(scan_frame_end),
    .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_wdata(draw_wdata),
    .draw_ack(draw_ack), .draw_frame_done(draw_frame_done), .flip_pending(flip_pending),
    .mem_req(mem_req), .mem_we(mem_we), .mem_back(mem_back), .mem_x(mem_x), .mem_y(mem_y),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .flip_buffer(flip_buffer), .mem_error(mem_error)
`ifdef FB_FLIP_COUNT_EN
    , .flip_count(flip_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: acks after resp_lat extra cycles of mem_req; silent when disabled.
  logic        resp_en = 1'b0;
  int          resp_lat = 0;
  logic [31:0] resp_data = '0;
  int          wait_c = 0;
  always @(negedge clk) begin
    if (!resp_en || !mem_req) begin
      mem_ack <= 1'b0;
      wait_c  <= 0;
    end else if (mem_ack) begin
      mem_ack <= 1'b0;
    end else if (wait_c >= resp_lat) begin
      mem_ack   <= 1'b1;
      mem_rdata <= resp_data;
    end else begin
      wait_c <= wait_c + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_or();
    return {31'h0, scan_ack | draw_ack | flip_pending | mem_req | mem_we | mem_back |
            flip_buffer | mem_error} | scan_rdata | mem_wdata | {23'h0, mem_x} | {24'h0, mem_y};
  endfunction

  typedef struct {
    logic        is_draw;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    logic seen;
    resp_en = 1'b1; resp_lat = v.lat; resp_data = v.rdata;
    if (v.is_draw) begin
      draw_x = v.x; draw_y = v.y; draw_wdata = v.wdata; draw_req = 1'b1;
    end else begin
      scan_x = v.x; scan_y = v.y; scan_req = 1'b1;
    end
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      seen = mem_req;
    end
    chk($sformatf("v%0d_grant_lat", idx), n, 1);
    chk($sformatf("v%0d_mem_x", idx), {23'h0, mem_x}, {23'h0, v.x});
    chk($sformatf("v%0d_mem_y", idx), {24'h0, mem_y}, {24'h0, v.y});
    chk($sformatf("v%0d_mem_we", idx), {31'h0, mem_we}, {31'h0, v.is_draw});
    chk($sformatf("v%0d_mem_back", idx), {31'h0, mem_back}, {31'h0, v.is_draw});
    if (v.is_draw) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.wdata);
    seen = 1'b0; n = 0;
    while (!seen && n < 100) begin
      @(negedge clk); n++;
      seen = scan_ack | draw_ack;
    end
    chk($sformatf("v%0d_ack_lat", idx), n, v.lat + 1);
    chk($sformatf("v%0d_scan_ack", idx), {31'h0, scan_ack}, {31'h0, !v.is_draw});
    chk($sformatf("v%0d_draw_ack", idx), {31'h0, draw_ack}, {31'h0, v.is_draw});
    chk($sformatf("v%0d_req_low", idx), {31'h0, mem_req}, 32'h0);
    if (!v.is_draw) chk($sformatf("v%0d_rdata", idx), scan_rdata, v.exp_rdata);
    scan_req = 1'b0; draw_req = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ack_pulse", idx), {31'h0, scan_ack | draw_ack}, 32'h0);
  endtask

  initial begin
    logic q[$];
    int n, flips, flips_pre;
    logic bad, seen;
`ifdef FB_FLIP_COUNT_EN
    logic [15:0] fc0;
`endif
    vecs[0] = '{1'b0, 9'd5,   8'd3,   32'h0,         32'hDEADBEEF, 1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 9'd319, 8'd239, 32'hA5A51234,  32'h0,        0, 32'h0};
    vecs[2] = '{1'b0, 9'd319, 8'd0,   32'h0,         32'h00000001, 3, 32'h00000001};
    vecs[3] = '{1'b1, 9'd0,   8'd0,   32'hFFFFFFFF,  32'h0,        2, 32'h0};
    vecs[4] = '{1'b0, 9'd0,   8'd239, 32'h0,         32'h80000000, 0, 32'h80000000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_or(), 32'h0);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {31'h0, mem_req}, 32'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Starvation guard: both requesters held, ack one cycle after request
    resp_en = 1'b1; resp_lat = 0; resp_data = 32'h12345678;
    scan_x = 9'd10; scan_y = 8'd20; draw_x = 9'd30; draw_y = 8'd40; draw_wdata = 32'hCAFE0001;
    scan_req = 1'b1; draw_req = 1'b1;
    n = 0;
    while (q.size() < 18 && n < 400) begin
      @(negedge clk); n++;
      if (scan_ack) q.push_back(1'b0);
      if (draw_ack) begin
        q.push_back(1'b1);
        chk("starve_draw_we", {30'h0, mem_we, mem_back}, 32'h3);
      end
    end
    scan_req = 1'b0; draw_req = 1'b0;
    chk("starve_ack_count", q.size(), 18);
    for (int i = 0; i < 18 && i < q.size(); i++)
      chk($sformatf("starve_ack%0d_is_draw", i), {31'h0, q[i]}, {31'h0, (i == 8 || i == 17)});
    repeat (3) @(negedge clk);

    // Deferred flip: draw blocked while flip pending, flip at first IDLE after frame end
`ifdef FB_FLIP_COUNT_EN
    fc0 = flip_count;
`endif
    draw_frame_done = 1'b1;
    @(negedge clk);
    draw_frame_done = 1'b0;
    chk("flip_pending_set", {31'h0, flip_pending}, 32'h1);
    draw_x = 9'd7; draw_y = 8'd9; draw_req = 1'b1; resp_lat = 1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!flip_pending || mem_req || flip_buffer) bad = 1'b1;
    end
    chk("draw_blocked_while_pending", {31'h0, bad}, 32'h0);
    scan_frame_end = 1'b1;
    @(negedge clk);
    scan_frame_end = 1'b0;
    chk("flip_not_yet", {30'h0, flip_buffer, flip_pending}, 32'h1);
    @(negedge clk);
    chk("flip_pulse", {30'h0, flip_buffer, flip_pending}, 32'h2);
    chk("no_grant_in_flip", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("flip_single", {31'h0, flip_buffer}, 32'h0);
    chk("draw_after_flip", {30'h0, mem_req, mem_we}, 32'h3);
`ifdef FB_FLIP_COUNT_EN
    chk("flip_count_deferred", {16'h0, flip_count}, {16'h0, fc0 + 16'd1});
`endif
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++; seen = draw_ack;
    end
    chk("deferred_draw_ack", {31'h0, seen}, 32'h1);
    draw_req = 1'b0;
    repeat (2) @(negedge clk);

    // Stale end-of-frame: must not trigger a later flip
    scan_frame_end = 1'b1;
    @(negedge clk);
    scan_frame_end = 1'b0;
    repeat (3) @(negedge clk);
    draw_frame_done = 1'b1;
    @(negedge clk);
    draw_frame_done = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (flip_buffer) bad = 1'b1;
    end
    chk("stale_frame_end_no_flip", {30'h0, bad, flip_pending}, 32'h1);
    scan_frame_end = 1'b1;
    @(negedge clk);
    scan_frame_end = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale_cleanup_flip", {31'h0, flip_pending}, 32'h0);

    // Simultaneous frame_done/frame_end during a draw transaction
`ifdef FB_FLIP_COUNT_EN
    fc0 = flip_count;
`endif
    resp_lat = 4; draw_req = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++; seen = mem_req;
    end
    chk("sim_draw_grant", {31'h0, seen}, 32'h1);
    draw_frame_done = 1'b1; scan_frame_end = 1'b1;
    @(negedge clk);
    draw_frame_done = 1'b0; scan_frame_end = 1'b0;
    flips = 0; flips_pre = 0; seen = 1'b0; n = 0;
    while (n < 30) begin
      if (flip_buffer) begin
        flips++;
        if (!seen) flips_pre++;
      end
      if (draw_ack) begin seen = 1'b1; draw_req = 1'b0; end
      @(negedge clk); n++;
    end
    chk("sim_draw_ack_seen", {31'h0, seen}, 32'h1);
    chk("sim_flip_count", flips, 1);
    chk("sim_flip_before_ack", flips_pre, 0);
    chk("sim_pending_clear", {31'h0, flip_pending}, 32'h0);
`ifdef FB_FLIP_COUNT_EN
    chk("flip_count_sim", {16'h0, flip_count}, {16'h0, fc0 + 16'd1});
`endif

    // Timeout: no mem_ack ever
    resp_en = 1'b0; scan_x = 9'd1; scan_y = 8'd2; scan_req = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++; seen = mem_req;
    end
    chk("to_grant", {31'h0, seen}, 32'h1);
    n = 0; bad = 1'b0;
    while (mem_req && n < 200) begin
      n++;
      @(negedge clk);
      if (scan_ack) bad = 1'b1;
    end
    chk("to_req_cycles", n, 64);
    chk("to_mem_error", {31'h0, mem_error}, 32'h1);
    @(negedge clk);
    if (scan_ack) bad = 1'b1;
    chk("to_no_scan_ack", {31'h0, bad}, 32'h0);
    chk("to_regrant", {31'h0, mem_req}, 32'h1);

    // Asynchronous reset with the retried transaction in flight
    #2 n_rst = 1'b0;
    #1 chk("rst_drops_req", {31'h0, mem_req}, 32'h0);
    chk("rst_all_zero", out_or(), 32'h0);
    scan_req = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (scan_ack || draw_ack || mem_req) bad = 1'b1;
    end
    chk("rst_no_ack_after", {30'h0, bad, mem_error}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
- Sequences all accesses to the double-buffered framebuffer memory. There are two requesters: display scanout (reads the front buffer) and the drawing engine (writes the back buffer).
- Drives the x/y coordinates and the buffer-flip pulse consumed by the framebuffer address generator, and runs a single-outstanding req/ack transaction on the memory bus.
- Defers a draw-requested buffer flip until scanout reaches end-of-frame, so displayed frames never tear.

Parameters:
- MAX_SCAN_RUN, 8, consecutive scan grants allowed while a draw is pending before one draw grant is forced (range 1..255).
- ACK_TIMEOUT, 64, cycles to wait for mem_ack before aborting a transaction (range 2..255).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- scan_req  input  1  scanout read request; held until scan_ack
- scan_x  input  9  scanout pixel x (0..319)
- scan_y  input  8  scanout pixel y (0..239)
- scan_ack  output  1  one-cycle pulse; scan_rdata valid this cycle
- scan_rdata  output  32  read data captured from mem_rdata
- scan_frame_end  input  1  one-cycle pulse at the end of each displayed frame
- draw_req  input  1  draw write request; held until draw_ack
- draw_x  input  9  draw pixel x
- draw_y  input  8  draw pixel y
- draw_wdata  input  32  pixel write data
- draw_ack  output  1  one-cycle pulse; write completed
- draw_frame_done  input  1  one-cycle pulse: back buffer complete, flip requested
- flip_pending  output  1  flip requested but not yet performed
- mem_req  output  1  memory transaction active
- mem_we  output  1  1 = write (draw), 0 = read (scan)
- mem_back  output  1  1 = transaction targets the back buffer
- mem_x  output  9  coordinate to the address generator
- mem_y  output  8  coordinate to the address generator
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  transaction complete
- flip_buffer  output  1  one-cycle pulse toggling front/back buffer
- mem_error  output  1  sticky flag: an ACK_TIMEOUT abort has occurred

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-low on n_rst.
  - On reset, every output is 0, including scan_rdata and the mem_* buses. Internal state goes to IDLE with counters cleared.
  - Reset asserted mid-transaction drops mem_req immediately, and no ack is issued for that transaction.
- States:
  - IDLE: no transaction.
  - SCAN_ACC: read in flight.
  - DRAW_ACC: write in flight.
- Arbitration (evaluated only in IDLE):
  - Scan has priority.
  - A draw is eligible only when draw_req=1 and flip_pending=0.
  - Draw wins if scan_req=0, or if run_cnt >= MAX_SCAN_RUN while a draw is eligible.
  - run_cnt increments on each scan grant made while a draw is eligible, and clears on a draw grant.
- Transaction timing:
  - Grant in IDLE at cycle N: at edge N+1, mem_x/mem_y/mem_we/mem_back/mem_wdata are registered from the winner and mem_req=1.
  - For scan: mem_we=0, mem_back=0.
  - For draw: mem_we=1, mem_back=1.
  - Outputs stay stable while mem_req=1.
- Completion:
  - mem_ack sampled high in an ACC state ends the transaction.
  - Next cycle: mem_req=0, the requester's ack pulses for exactly 1 cycle, and scan reads capture scan_rdata.
  - The state returns to IDLE in that same cycle.
  - Minimum spacing between grants is 3 cycles (grant, ack, idle).
- Timeout:
  - A wait counter runs while mem_req=1.
  - When it reaches ACK_TIMEOUT without mem_ack: drop mem_req, set mem_error, return to IDLE, and issue no requester ack.
  - The requester retries because its req is still held.
- Flip sequencing:
  - draw_frame_done sets flip_pending. A repeat while pending is ignored.
  - scan_frame_end sets an internal frame_end_seen flag.
  - In IDLE with both flags set: flip_buffer pulses 1 cycle, and both flags clear on the same edge.
  - If scan_frame_end arrives during an ACC state, the flip waits until the first IDLE cycle.
  - If draw_frame_done and scan_frame_end occur in the same cycle, the flip fires the next IDLE cycle.
  - frame_end_seen without a pending flip clears on the next IDLE cycle, so a stale end-of-frame never triggers a later flip.
  - In a flip cycle, no new grant is made; arbitration resumes the following cycle.
- Ignored inputs: mem_ack while in IDLE is ignored.

Optional Feature:
- Macro: FB_FLIP_COUNT_EN.
- When defined, an extra output flip_count (16 bits) is added. It resets to 0, increments on every flip_buffer pulse, and wraps 65535 -> 0.
- When undefined, the port and its counter are absent, with no other behavioural change.

Test Plan:
- Reset with a transaction in flight: assert n_rst=0 while mem_req=1 -> mem_req=0 asynchronously; no scan_ack/draw_ack; all outputs 0.
- Single scan read: scan_req=1, x=5, y=3; mem_ack after 2 cycles with rdata=0xDEADBEEF -> mem_x=5, mem_y=3, mem_we=0, mem_back=0; scan_ack 1 cycle with scan_rdata=0xDEADBEEF.
- Starvation guard: scan_req and draw_req held continuously, MAX_SCAN_RUN=8, mem_ack always after 1 cycle -> exactly 8 scan acks, then 1 draw_ack with mem_we=1, mem_back=1; pattern repeats.
- Deferred flip: draw_frame_done pulse, scan_frame_end 20 cycles later -> flip_pending=1 throughout, draw blocked, flip_buffer single pulse in the first IDLE cycle after scan_frame_end, flip_pending=0 afterwards.
- Simultaneous events: draw_frame_done and scan_frame_end in the same cycle during DRAW_ACC -> exactly one flip_buffer pulse after draw_ack; with FB_FLIP_COUNT_EN, flip_count goes 0 -> 1.
- Timeout: scan_req with mem_ack never asserted, ACK_TIMEOUT=64 -> mem_req drops after 64 cycles, mem_error=1, no scan_ack, the request is re-granted.
